dram_responder: RTL
===================

# dram_responder

Clocked DRAM-side model for the VG8020 RAM subsystem. It samples the multiplexed-address strobes produced by the RAS/CAS control logic (nras, ncas, nwe, ma) with an oversampling clock and latches row and column. It serves reads and writes from an internal array and tracks refresh coverage. It is the memory end of the strobe protocol, used in benches and FPGA builds in place of the 4164 bank.

## Interface
- ADDR_BITS, 8, width of multiplexed address; array depth 2^(2*ADDR_BITS)
- DATA_BITS, 8, data width
- REFRESH_ROWS, 128, rows that must be refreshed per window (row = low log2(REFRESH_ROWS) bits of row address)
- REFRESH_WINDOW, 57344, window length in clk cycles (2 ms at 28.67 MHz)
- clk  in  1  oversampling clock, ≥8x CPU clock; single clock domain
- nreset  in  1  reset, asynchronous, active-low
- nras  in  1  row strobe, asynchronous to clk
- ncas  in  1  column strobe, asynchronous to clk
- nwe  in  1  write enable, low = write
- ma  in  ADDR_BITS  multiplexed address
- din  in  DATA_BITS  write data
- dout  out  DATA_BITS  read data
- doe  out  1  dout valid / drive enable
- refresh_err  out  1  sticky refresh-violation flag

## Operation
- nras, ncas, nwe, ma and din pass through identical 2-flop synchronizers. All decisions use the synchronized copies (s_*). Edges are detected against the previous s_ sample.
- States: IDLE, ROW, COL, CBR, HOLD.
- IDLE: s_nras falls with s_ncas high → latch row = s_ma, go to ROW. s_ncas falls with s_nras high → CBR.
- Both fall in the same sample → normal access. Row = that s_ma, go to ROW. Column is taken from the next sample.
- ROW: s_ncas falls → latch col = s_ma, go to COL. s_nras rises with no CAS in the cycle → RAS-only refresh of row, go to IDLE.
- COL, s_nwe low at entry (early write): mem[{row,col}] ← s_din in the entry cycle. doe stays 0.
- COL, s_nwe high at entry (read): dout ← mem[{row,col}]. doe = 1 one clk after entry.
- COL, s_nwe falls while in COL (late write): write s_din once, drop doe.
- COL, s_ncas rises with s_nras low → ROW (page mode; row kept, doe = 0).
- COL, s_nras rises with s_ncas low → HOLD. The row counts as refreshed.
- HOLD: dout and doe are held. s_ncas rises → doe = 0, go to IDLE.
- CBR: s_nras falls → internal refresh counter row refreshed, counter increments mod REFRESH_ROWS. Both high → IDLE.
- Every completed access (COL entry) also marks its row refreshed.
- Array contents are not cleared by reset.

## Timing
- Input-to-decision latency: 2 clk (synchronizers) + 1 clk (edge detect).
- Read: doe and dout valid 4 clk after the ncas pin falls. doe deasserts 3 clk after the ncas pin rises (HOLD) or after the state leaves COL.
- ma must be stable from 1 clk before to 3 clk after each strobe's pin edge. din must be stable 3 clk after the later of the ncas fall and the nwe fall.
- Reset values: dout = 0, doe = 0, refresh_err = 0, state IDLE, refresh counter 0, window counter 0, coverage bitmap clear.
- nreset asserted mid-access: outputs go to reset values immediately. An in-flight write is dropped unless it already committed on an earlier clk.

## Configuration
- DRAM_REFRESH_CHECK_EN defined: a REFRESH_ROWS-bit coverage bitmap and a window counter are built.
- At the window counter wrap (REFRESH_WINDOW-1 → 0), any clear bit sets refresh_err until nreset, then the bitmap clears.
- A refresh on the wrap cycle counts for the new window.
- DRAM_REFRESH_CHECK_EN undefined: no bitmap or window counter. refresh_err is tied to 0. The CBR counter still exists.

## Structure
- Shared include dram_defs.v: state encodings, REFRESH_ROWS/REFRESH_WINDOW defaults, row-index width derivation.
- Sub-module dram_strobe_sync: 2-flop synchronizer plus previous-sample register with rise/fall pulses. It is instantiated once with a width parameter covering all inputs.

## Test plan
- Read: preload mem[0x1234] = 0xA5. Drive nras low with ma = 0x12, then ncas low with ma = 0x34, nwe high → doe = 1, dout = 0xA5 at ncas + 4 clk. doe = 0 after ncas rises.
- Early write: nwe low before ncas at row 0x12, col 0x35, din = 0x5A. Then read back the same address → dout = 0x5A, doe = 0 during the write.
- Page mode: RAS held low at row 0x40, three CAS pulses at cols 0x00/0x01/0x02 reading preloaded 0x11/0x22/0x33 → dout sequence 0x11, 0x22, 0x33.
- Refresh: RAS-only pulses on rows 0..127 inside one window → refresh_err = 0. Omit row 0x05 in the next window → refresh_err = 1 at the wrap and it stays set.
- CBR: 128 CBR cycles → counter wraps to 0 and all bits are set. With DRAM_REFRESH_CHECK_EN undefined, refresh_err stays 0.
- Reset mid-read: nreset low while doe = 1 → doe = 0 and dout = 0 immediately. A following read of mem[0x1234] still returns 0xA5.

Source files
------------

// File: rtl/dram_responder_pkg.sv
// dram_responder shared definitions: FSM states, refresh defaults,
// and the row-index width helper.
package dram_responder_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ROW,
      S_COL,
      S_CBR,
      S_HOLD
   } state_t;

   localparam int REFRESH_ROWS_DEF   = 128;
   localparam int REFRESH_WINDOW_DEF = 57344;

   function automatic int ridx_bits(input int rows);
      return (rows > 1) ? $clog2(rows) : 1;
   endfunction

endpackage

// File: rtl/dram_responder_strobe_sync.sv
// Two-flop synchronizer for all DRAM pins, plus a previous-sample
// register and rise/fall pulses on the low E (strobe) bits.
module dram_responder_strobe_sync #(
   parameter int W = 8,
   parameter int E = 1
) (
   input  logic         clk,
   input  logic         nreset,
   input  logic [W-1:0] d,
   output logic [W-1:0] s,
   output logic [E-1:0] fall,
   output logic [E-1:0] rise
);

   logic [W-1:0] m;
   logic [E-1:0] p;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         m <= '0;
         s <= '0;
         p <= '0;
      end else begin
         m <= d;
         s <= m;
         p <= s[E-1:0];
      end
   end

   assign fall = p & ~s[E-1:0];
   assign rise = ~p & s[E-1:0];

endmodule

// File: rtl/dram_responder.sv
// DRAM-side strobe responder with array, CBR counter and refresh tracking.
// Define DRAM_REFRESH_CHECK_EN to build the refresh coverage checker.
module dram_responder
   import dram_responder_pkg::*;
#(
   parameter int ADDR_BITS      = 8,
   parameter int DATA_BITS      = 8,
   parameter int REFRESH_ROWS   = REFRESH_ROWS_DEF,
   parameter int REFRESH_WINDOW = REFRESH_WINDOW_DEF
) (
   input  logic                 clk,
   input  logic                 nreset,
   input  logic                 nras,
   input  logic                 ncas,
   input  logic                 nwe,
   input  logic [ADDR_BITS-1:0] ma,
   input  logic [DATA_BITS-1:0] din,
   output logic [DATA_BITS-1:0] dout,
   output logic                 doe,
   output logic                 refresh_err
);

   localparam int RB    = ridx_bits(REFRESH_ROWS);
   localparam int SW    = 3 + ADDR_BITS + DATA_BITS;
   localparam int DEPTH = 1 << (2 * ADDR_BITS);

   logic [SW-1:0]        sv;
   logic [2:0]           fl, rs;
   logic                 s_nras, s_ncas, s_nwe;
   logic [ADDR_BITS-1:0] s_ma;
   logic [DATA_BITS-1:0] s_din;

   dram_responder_strobe_sync #(.W(SW), .E(3)) u_sync (
      .clk    (clk),
      .nreset (nreset),
      .d      ({din, ma, nwe, ncas, nras}),
      .s      (sv),
      .fall   (fl),
      .rise   (rs)
   );

   assign {s_din, s_ma, s_nwe, s_ncas, s_nras} = sv;

   state_t                   state, state_n;
   logic [ADDR_BITS-1:0]     row, row_n, col, col_n;
   logic                     wmode, wmode_n, doe_n, rd, we;
   logic [2*ADDR_BITS-1:0]   waddr;
   logic                     ref_hit, cbr_inc;
   logic [RB-1:0]            ref_idx, cbr_cnt;
   logic [DATA_BITS-1:0]     mem [DEPTH];

   always_comb begin
      state_n = state;
      row_n   = row;
      col_n   = col;
      wmode_n = wmode;
      doe_n   = doe;
      rd      = 1'b0;
      we      = 1'b0;
      waddr   = {row, col};
      ref_hit = 1'b0;
      ref_idx = row[RB-1:0];
      cbr_inc = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (fl[0]) begin
               row_n   = s_ma;
               state_n = S_ROW;
            end else if (fl[1] && s_nras) begin
               state_n = S_CBR;
            end
         end
         // CAS level (not edge) also catches RAS+CAS falling together
         S_ROW: begin
            if (!s_ncas) begin
               col_n   = s_ma;
               wmode_n = !s_nwe;
               ref_hit = 1'b1;
               state_n = S_COL;
               if (!s_nwe) begin
                  we    = 1'b1;
                  waddr = {row, s_ma};
               end
            end else if (rs[0]) begin
               ref_hit = 1'b1;
               state_n = S_IDLE;
            end
         end
         S_COL: begin
            if (rs[1]) begin
               doe_n   = 1'b0;
               state_n = s_nras ? S_IDLE : S_ROW;
            end else begin
               if (rs[0]) begin
                  ref_hit = 1'b1;
                  state_n = S_HOLD;
               end
               if (!wmode && fl[2]) begin
                  we      = 1'b1;
                  wmode_n = 1'b1;
                  doe_n   = 1'b0;
               end else if (!wmode) begin
                  rd    = 1'b1;
                  doe_n = 1'b1;
               end
            end
         end
         S_HOLD: begin
            if (s_ncas) begin
               doe_n   = 1'b0;
               state_n = S_IDLE;
            end
         end
         S_CBR: begin
            if (fl[0]) begin
               ref_hit = 1'b1;
               ref_idx = cbr_cnt;
               cbr_inc = 1'b1;
            end
            if (s_nras && s_ncas) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state   <= S_IDLE;
         row     <= '0;
         col     <= '0;
         wmode   <= 1'b0;
         doe     <= 1'b0;
         dout    <= '0;
         cbr_cnt <= '0;
      end else begin
         state <= state_n;
         row   <= row_n;
         col   <= col_n;
         wmode <= wmode_n;
         doe   <= doe_n;
         if (rd) dout <= mem[{row, col}];
         if (cbr_inc)
            cbr_cnt <= (cbr_cnt == RB'(REFRESH_ROWS - 1)) ? '0 : cbr_cnt + 1'b1;
      end
   end

   // array survives reset
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= s_din;
   end

   logic unused_sync;
   assign unused_sync = rs[2];

`ifdef DRAM_REFRESH_CHECK_EN
   localparam int WB = (REFRESH_WINDOW > 1) ? $clog2(REFRESH_WINDOW) : 1;

   logic [WB-1:0]           wcnt;
   logic [REFRESH_ROWS-1:0] cov, hit_vec;
   logic                    err;

   assign hit_vec = ref_hit ? (REFRESH_ROWS'(1) << ref_idx) : '0;

   // a refresh landing on the wrap cycle seeds the new window
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         wcnt <= '0;
         cov  <= '0;
         err  <= 1'b0;
      end else if (wcnt == WB'(REFRESH_WINDOW - 1)) begin
         wcnt <= '0;
         cov  <= hit_vec;
         if (~&cov) err <= 1'b1;
      end else begin
         wcnt <= wcnt + 1'b1;
         cov  <= cov | hit_vec;
      end
   end

   assign refresh_err = err;
`else
   logic unused_ref;
   assign unused_ref  = ^{ref_hit, ref_idx, 32'(REFRESH_WINDOW)};
   assign refresh_err = 1'b0;
`endif

endmodule
